// File: rtl/otp_pkg.sv
// Shared constants and types for the one-time-pad APB requester/completer pair.
package otp_pkg;

  // Completer register map
  localparam logic [31:0] OTP_ADDR_KEY    = 32'h0000_0000;
  localparam logic [31:0] OTP_ADDR_DATA   = 32'h0000_0001;
  localparam logic [31:0] OTP_ADDR_RESULT = 32'h0000_0002;

  // Key writes are privileged, data and result accesses are normal
  localparam logic [2:0] PROT_KEY  = 3'b001;
  localparam logic [2:0] PROT_DATA = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_KEY_SETUP   = 3'd1,
    S_KEY_ACCESS  = 3'd2,
    S_DATA_SETUP  = 3'd3,
    S_DATA_ACCESS = 3'd4,
    S_RD_SETUP    = 3'd5,
    S_RD_ACCESS   = 3'd6,
    S_RESP        = 3'd7
  } otp_req_state_e;

  // Observation bundle: current FSM state plus the captured load-key flag
  typedef struct packed {
    otp_req_state_e state;
    logic           load_key;
  } otp_req_dbg_t;

  function automatic logic is_access(input otp_req_state_e s);
    return (s == S_KEY_ACCESS) || (s == S_DATA_ACCESS) || (s == S_RD_ACCESS);
  endfunction

endpackage

// File: rtl/apb_otp_requester.sv
// APB requester for the one-time-pad completer: takes one encrypt job,
// issues optional key write, data write and result read, returns the result.
//
// Handshakes: a transfer happens on a rising pclk edge where valid && ready.
// The request side only raises req_ready in IDLE, the response side holds
// rsp_valid/rsp_data/rsp_err stable until rsp_ready; one job in flight.
module apb_otp_requester
  import otp_pkg::*;
#(
  parameter int WIDTH   = 128,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               preset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_load_key,
  input  logic [WIDTH-1:0]   req_key,
  input  logic [WIDTH-1:0]   req_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
  output logic [31:0]        paddr,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [2:0]         pprot,
  output logic [WIDTH-1:0]   pwdata,
  input  logic [WIDTH-1:0]   prdata,
  input  logic               pready,
  output otp_req_dbg_t       dbg
);

  // Counter only needs to reach TIMEOUT-1: the abort fires on the cycle it would hit TIMEOUT
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  otp_req_state_e   state;
  otp_req_state_e   state_nxt;
  logic [WIDTH-1:0] key_q;
  logic [WIDTH-1:0] data_q;
  logic             load_key_q;
  logic [CW-1:0]    wait_cnt;
  logic             ready_en;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;

  logic in_access;
  logic timed_out;
  logic req_fire;
  logic rsp_fire;

  assign in_access = is_access(state);
  // pready has priority: a timeout only fires when the last allowed cycle also stalls
  assign timed_out = in_access && !pready && (wait_cnt == CNT_LAST);
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dbg       = '{state: state, load_key: load_key_q};

  // State register
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic: each transfer is SETUP then ACCESS until pready or timeout
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:        if (req_fire) state_nxt = req_load_key ? S_KEY_SETUP : S_DATA_SETUP;
      S_KEY_SETUP:   state_nxt = S_KEY_ACCESS;
      S_KEY_ACCESS:  if (pready) state_nxt = S_DATA_SETUP;
                     else if (timed_out) state_nxt = S_RESP;
      S_DATA_SETUP:  state_nxt = S_DATA_ACCESS;
      S_DATA_ACCESS: if (pready) state_nxt = S_RD_SETUP;
                     else if (timed_out) state_nxt = S_RESP;
      S_RD_SETUP:    state_nxt = S_RD_ACCESS;
      S_RD_ACCESS:   if (pready || timed_out) state_nxt = S_RESP;
      S_RESP:        if (rsp_fire) state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; reset forces IDLE so APB drops asynchronously
  always_comb begin
    psel      = 1'b0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    paddr     = '0;
    pprot     = '0;
    pwdata    = '0;
    case (state)
      S_KEY_SETUP, S_KEY_ACCESS: begin
        psel    = 1'b1;
        penable = (state == S_KEY_ACCESS);
        pwrite  = 1'b1;
        paddr   = OTP_ADDR_KEY;
        pprot   = PROT_KEY;
        pwdata  = key_q;
      end
      S_DATA_SETUP, S_DATA_ACCESS: begin
        psel    = 1'b1;
        penable = (state == S_DATA_ACCESS);
        pwrite  = 1'b1;
        paddr   = OTP_ADDR_DATA;
        pprot   = PROT_DATA;
        pwdata  = data_q;
      end
      S_RD_SETUP, S_RD_ACCESS: begin
        psel    = 1'b1;
        penable = (state == S_RD_ACCESS);
        paddr   = OTP_ADDR_RESULT;
        pprot   = PROT_DATA;
      end
      default: ;
    endcase
    rsp_valid = (state == S_RESP);
    req_ready = (state == S_IDLE) && ready_en;
  end

  // Keep req_ready low while in reset and for the first edge after release
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) ready_en <= 1'b0;
    else           ready_en <= 1'b1;
  end

  // Capture the job on the request handshake; later req_* changes are ignored
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      key_q      <= '0;
      data_q     <= '0;
      load_key_q <= 1'b0;
    end else if (state == S_IDLE && req_fire) begin
      key_q      <= req_key;
      data_q     <= req_data;
      load_key_q <= req_load_key;
    end
  end

  // Wait-state counter: zero outside ACCESS, counts stalled ACCESS cycles
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)                         wait_cnt <= '0;
    else if (!in_access)                   wait_cnt <= '0;
    else if (!pready && wait_cnt != CNT_LAST) wait_cnt <= wait_cnt + CW'(1);
  end

  // Response capture: read data on success, zero plus error on timeout
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (state == S_RD_ACCESS && pready) begin
      rsp_data_q <= prdata;
      rsp_err_q  <= 1'b0;
    end else if (timed_out) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b1;
    end else if (rsp_fire) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end
  end

endmodule

// File: doc/apb_otp_requester.md
Name: apb_otp_requester

Overview:
APB requester stage that sits directly upstream of the one-time-pad APB completer and drives its register interface.
- Accepts an encrypt job (optional key, data word) on a valid/ready request port.
- Sequences APB transfers: key write to addr 0x0 (privileged), data write to addr 0x1, result read from addr 0x2.
- Returns the read result, or an error, on a valid/ready response port.

Parameters:
- WIDTH, 128, data/key/result width; matches the completer's pwdata/prdata width.
- TIMEOUT, 16, max access-phase cycles waiting for pready before aborting (>=1).

Ports:
- pclk  in  1  clock
- preset_n  in  1  async active-low reset
- req_valid  in  1  job offered
- req_ready  out  1  job accepted when req_valid && req_ready
- req_load_key  in  1  1 = write req_key before data
- req_key  in  WIDTH  key
- req_data  in  WIDTH  plaintext
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  WIDTH  read result (0 on error)
- rsp_err  out  1  a transfer timed out
- paddr  out  32  APB address
- psel  out  1  APB select
- penable  out  1  APB access phase
- pwrite  out  1  APB direction
- pprot  out  3  APB protection
- pwdata  out  WIDTH  APB write data
- prdata  in  WIDTH  APB read data
- pready  in  1  APB completion

Behaviour:
- Reset: all outputs 0; FSM = IDLE; captured key/data/load flag cleared; timeout counter 0. Reset asserted mid-job abandons the job immediately with no response; APB outputs drop to 0 asynchronously.
- States: IDLE, KEY_SETUP, KEY_ACCESS, DATA_SETUP, DATA_ACCESS, RD_SETUP, RD_ACCESS, RESP.
- IDLE: req_ready=1. On handshake, register req_key, req_data and req_load_key. Go to KEY_SETUP if load_key=1, else DATA_SETUP.
- SETUP states (one cycle): psel=1, penable=0, paddr/pwrite/pprot/pwdata stable. Next state is the matching ACCESS state.
- ACCESS states: psel=1, penable=1, same address/control as SETUP. Completion = pready sampled 1 at posedge.
  - KEY_ACCESS completes -> DATA_SETUP.
  - DATA_ACCESS completes -> RD_SETUP.
  - RD_ACCESS completes -> capture prdata into rsp_data, rsp_err=0 -> RESP.
- Transfer encodings:
  - Key: paddr=0x0, pwrite=1, pprot=3'b001, pwdata=key.
  - Data: paddr=0x1, pwrite=1, pprot=3'b000, pwdata=data.
  - Read: paddr=0x2, pwrite=0, pprot=3'b000, pwdata=0.
- Timeout:
  - Counter clears on entry to each ACCESS state and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT with pready still 0: deassert psel/penable next cycle, rsp_err=1, rsp_data=0 -> RESP. Remaining transfers are skipped.
  - If pready=1 in the same cycle the counter reaches TIMEOUT, the transfer completes normally (success has priority).
- Outputs outside SETUP/ACCESS: psel, penable and pwrite are 0; paddr/pprot/pwdata are 0 in IDLE and RESP.
- RESP: rsp_valid=1, rsp_data/rsp_err held stable until rsp_ready. On handshake -> IDLE; req_ready rises the following cycle. There is no request/response overlap: one job in flight.
- Latency with zero-wait-state pready: a job without key runs handshake -> RESP in 5 cycles (2 per transfer + accept); with key, 7 cycles.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package otp_pkg holds:
  - address constants OTP_ADDR_KEY=0x0, OTP_ADDR_DATA=0x1, OTP_ADDR_RESULT=0x2;
  - pprot constants PROT_KEY=3'b001, PROT_DATA=3'b000;
  - FSM state enum otp_req_state_e.
- Single module; no sub-module. The timeout counter is inline.

Test Plan:
1. load_key=1, key=0xFF..FF, data=0x0123_4567_89AB_CDEF, completer model gives zero-wait pready and prdata=key^data -> three APB transfers in order at 0x0 (pprot 001), 0x1, 0x2; rsp_data=0xFFFF_FFFF_FFFF_FFFF_FEDC_BA98_7654_3210, rsp_err=0, RESP entered 7 cycles after accept.
2. load_key=0, data=0xA5 -> no write to 0x0; writes 0x1 then reads 0x2; rsp_valid after 5 cycles.
3. pready held 0 in DATA_ACCESS, TIMEOUT=16 -> abort after 16 access cycles; rsp_err=1, rsp_data=0; no read to 0x2 issued.
4. pready=1 exactly on the 16th wait cycle -> transfer completes, rsp_err=0.
5. rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout; handshake -> IDLE, next job accepted.
6. preset_n pulsed low during RD_ACCESS -> psel/penable drop to 0 immediately, rsp_valid stays 0, req_ready=1 after reset release.
